// File: rtl/mapa_shot_arbiter.sv
// mapa_shot_arbiter: battleship turn/shot arbiter with frame-tick map commits; MAPA_HIT_REPEAT_EN lets a hitting player shoot again
module mapa_shot_arbiter #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int SHIP_CELLS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       load_we,
  input  logic       load_map,
  input  logic [2:0] load_row,
  input  logic [2:0] load_col,
  input  logic       p1_req,
  input  logic [2:0] p1_row,
  input  logic [2:0] p1_col,
  input  logic       p2_req,
  input  logic [2:0] p2_row,
  input  logic [2:0] p2_col,
  output logic       turn,
  output logic       shot_ack,
  output logic       shot_hit,
  output logic       shot_reject,
  input  logic       rd_map,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_state,
  output logic       game_over,
  output logic       winner
);
  typedef enum logic [2:0] {SETUP, TURN, RESOLVE, WAIT_FRAME, GAME_OVER} state_t;
  state_t state, state_nx;
  logic [1:0] cells [128];
  logic [6:0] hits [2];
  logic [2:0] tr, tc, rr, rc;
  logic [1:0] was, tgt, armed;
  logic req, hit, win_now;

  function automatic logic in_rng(logic [2:0] r, logic [2:0] c);
    return int'(r) < ROWS && int'(c) < COLS;
  endfunction

  always_comb begin
    req = turn ? p2_req : p1_req;
    rr = turn ? p2_row : p1_row;
    rc = turn ? p2_col : p1_col;
    tgt = cells[{~turn, tr, tc}];
    hit = was == 2'd1;
    win_now = hit && hits[turn] == 7'(SHIP_CELLS - 1);
    state_nx = state;
    case (state)
      SETUP:      state_nx = start ? TURN : SETUP;
      TURN:       state_nx = (req && armed[turn]) ? RESOLVE : TURN;
      RESOLVE:    state_nx = (!in_rng(tr, tc) || tgt[1]) ? TURN : WAIT_FRAME;
      WAIT_FRAME: state_nx = frame_tick ? (win_now ? GAME_OVER : TURN) : WAIT_FRAME;
      default:    state_nx = state;
    endcase
  end

  always_ff @(posedge clk) state <= rst ? SETUP : state_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) cells[i] <= 2'd0;
      hits[0] <= 7'd0;
      hits[1] <= 7'd0;
      {turn, shot_ack, shot_hit, shot_reject, game_over, winner} <= 6'd0;
      armed <= 2'b11;
      {tr, tc, was, rd_state} <= 10'd0;
    end else begin
      shot_ack <= 1'b0;
      shot_reject <= 1'b0;
      armed <= armed | ~{p2_req, p1_req};
      rd_state <= in_rng(rd_row, rd_col) ? cells[{rd_map, rd_row, rd_col}] : 2'd0;
      if (state == SETUP && load_we && in_rng(load_row, load_col))
        cells[{load_map, load_row, load_col}] <= 2'd1;
      if (state == TURN && req && armed[turn]) begin
        tr <= rr;
        tc <= rc;
      end
      if (state == RESOLVE) begin
        was <= tgt;
        if (state_nx == TURN) begin
          shot_reject <= 1'b1;
          armed[turn] <= 1'b0;
        end
      end
      // the only map write after SETUP lands here, inside vertical blanking
      if (state == WAIT_FRAME && frame_tick) begin
        cells[{~turn, tr, tc}] <= hit ? 2'd3 : 2'd2;
        if (hit && hits[turn] != 7'(SHIP_CELLS)) hits[turn] <= hits[turn] + 7'd1;
        shot_ack <= 1'b1;
        shot_hit <= hit;
        armed[turn] <= 1'b0;
        if (win_now) begin
          game_over <= 1'b1;
          winner <= turn;
        end else begin
`ifdef MAPA_HIT_REPEAT_EN
          turn <= hit ? turn : ~turn;
`else
          turn <= ~turn;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_mapa_shot_arbiter.sv
// tb_mapa_shot_arbiter: randomized scoreboard bench against a cell-array game model
module tb_mapa_shot_arbiter;
  localparam int R = 7, C = 6, S = 3;
`ifdef MAPA_HIT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 0, rst = 1, frame_tick = 0, start = 0, load_we = 0, load_map = 0;
  logic [2:0] load_row = 0, load_col = 0;
  logic p1_req = 0, p2_req = 0;
  logic [2:0] p1_row = 0, p1_col = 0, p2_row = 0, p2_col = 0;
  logic turn, shot_ack, shot_hit, shot_reject, game_over, winner;
  logic rd_map = 0;
  logic [2:0] rd_row = 0, rd_col = 0;
  logic [1:0] rd_state;

  always #5 clk = ~clk;

  mapa_shot_arbiter #(.ROWS(R), .COLS(C), .SHIP_CELLS(S)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .load_we(load_we), .load_map(load_map), .load_row(load_row), .load_col(load_col),
    .p1_req(p1_req), .p1_row(p1_row), .p1_col(p1_col),
    .p2_req(p2_req), .p2_row(p2_row), .p2_col(p2_col),
    .turn(turn), .shot_ack(shot_ack), .shot_hit(shot_hit), .shot_reject(shot_reject),
    .rd_map(rd_map), .rd_row(rd_row), .rd_col(rd_col), .rd_state(rd_state),
    .game_over(game_over), .winner(winner)
  );

  typedef struct packed {logic rej; logic hit; logic go; logic win; logic trn;} resp_t;
  resp_t q[$];
  int total = 0, bad = 0;
  int mdl [2][8][8];
  int hits [2];
  bit m_turn, m_over, m_win, m_setup;

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  function automatic int mread(bit m, int r, int c);
    return (r < R && c < C) ? mdl[m][r][c] : 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1; frame_tick = 0; start = 0; load_we = 0; p1_req = 0; p2_req = 0;
    cyc();
    cyc();
    rst = 0;
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) mdl[m][r][c] = 0;
    hits[0] = 0; hits[1] = 0;
    m_turn = 0; m_over = 0; m_win = 0; m_setup = 1;
    q.delete();
  endtask

  task automatic rd(bit m, int r, int c);
    rd_map = m; rd_row = 3'(r); rd_col = 3'(c);
    cyc();
    chk($sformatf("rd m%0d r%0d c%0d", m, r, c), 8'(rd_state), 8'(mread(m, r, c)));
  endtask

  task automatic load(bit m, int r, int c, bit st);
    load_we = 1; load_map = m; load_row = 3'(r); load_col = 3'(c); start = st;
    cyc();
    load_we = 0; start = 0;
    if (m_setup && r < R && c < C) mdl[m][r][c] = 1;
    if (st) m_setup = 0;
  endtask

  task automatic shot(int r, int c, bit both, int hold);
    bit p = m_turn;
    bit exp_resp = !m_setup && !m_over;
    int pre = mread(!p, r, c);
    int d = $urandom_range(2, 5);
    int v;
    bit got = 0, ticked = 0;
    resp_t e;
    if (exp_resp) begin
      v = (r < R && c < C) ? mdl[!p][r][c] : 2;
      e = '0;
      e.trn = m_turn;
      if (v >= 2) e.rej = 1;
      else begin
        e.hit = (v == 1);
        mdl[!p][r][c] = (v == 1) ? 3 : 2;
        if (v == 1) hits[p]++;
        if (hits[p] == S) begin
          m_over = 1; m_win = p; e.go = 1; e.win = p;
        end else if (!(v == 1 && REP)) m_turn = !m_turn;
        e.trn = m_turn;
      end
      q.push_back(e);
    end
    rd_map = !p; rd_row = 3'(r); rd_col = 3'(c);
    p1_row = p ? 3'($urandom_range(0, 7)) : 3'(r);
    p1_col = p ? 3'($urandom_range(0, 7)) : 3'(c);
    p2_row = p ? 3'(r) : 3'($urandom_range(0, 7));
    p2_col = p ? 3'(c) : 3'($urandom_range(0, 7));
    p1_req = !p || both;
    p2_req = p || both;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n > 1 && !ticked) chk("no_early_write", 8'(rd_state), 8'(pre));
      if (shot_ack || shot_reject) got = 1;
      else begin
        if (!exp_resp && n == 12) break;
        @(posedge clk);
        #1;
        frame_tick = (n % d == 0);
        ticked |= frame_tick;
      end
    end
    frame_tick = 0;
    if (exp_resp && !got) begin
      total++; bad++;
      $display("FAIL shot_timeout r=%0d c=%0d got=none want=response", r, c);
      if (q.size() > 0) void'(q.pop_front());
    end
    if (p) p1_req = 0; else p2_req = 0;
    repeat (hold) cyc();
    p1_req = 0; p2_req = 0;
    cyc();
    cyc();
    chk("turn_after_shot", 8'(turn), 8'(m_turn));
  endtask

  always @(negedge clk) begin
    if (!rst && (shot_ack || shot_reject)) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp got ack=%0d rej=%0d want=none", shot_ack, shot_reject);
      end else begin
        resp_t e;
        e = q.pop_front();
        chk("shot_ack", 8'(shot_ack), 8'(!e.rej));
        chk("shot_reject", 8'(shot_reject), 8'(e.rej));
        if (!e.rej) chk("shot_hit", 8'(shot_hit), 8'(e.hit));
        chk("game_over", 8'(game_over), 8'(e.go));
        if (e.go) chk("winner", 8'(winner), 8'(e.win));
        else chk("turn_at_resp", 8'(turn), 8'(e.trn));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pick;
    reset_all();
    chk("rst_turn", 8'(turn), 0);
    chk("rst_game_over", 8'(game_over), 0);
    chk("rst_winner", 8'(winner), 0);
    chk("rst_ack", 8'(shot_ack), 0);
    chk("rst_reject", 8'(shot_reject), 0);
    chk("rst_hit", 8'(shot_hit), 0);
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) rd(m[0], r, c);
    load(1, 2, 3, 0); load(1, 6, 0, 0); load(1, 7, 0, 0); load(1, 5, 5, 0);
    load(0, 1, 1, 0); load(0, 1, 2, 0); load(0, 1, 3, 0); load(0, 0, 6, 0);
    load(1, 4, 4, 1);
    load(0, 5, 5, 0);
    rd(1, 2, 3); rd(1, 4, 4); rd(0, 5, 5); rd(1, 6, 0);
    chk("turn_after_start", 8'(turn), 0);
    shot(2, 3, 0, 0);
    rd(1, 2, 3);
    shot(0, 0, 0, 0);
    rd(0, 0, 0); rd(1, 0, 0);
    shot(2, 3, 0, 3);
    shot(1, 4, 1, 0);
    shot(7, 0, 0, 1);
    shot(0, 5, 1, 0);
    for (int i = 0; i < 200 && !m_over; i++) begin
      int r = $urandom_range(0, 7), c = $urandom_range(0, 7);
      pick = ($urandom_range(0, 2) == 0);
      for (int a = 0; a < R && pick; a++)
        for (int b = 0; b < C && pick; b++)
          if (mdl[!m_turn][a][b] == 1) begin
            r = a; c = b; pick = 0;
          end
      shot(r, c, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
    end
    chk("game_over_level", 8'(game_over), 8'(m_over));
    chk("winner_level", 8'(winner), 8'(m_win));
    shot(3, 3, 1, 0);
    load(0, 6, 5, 1);
    rd(0, 6, 5);
    chk("game_over_held", 8'(game_over), 1);
    reset_all();
    load(1, 0, 0, 1);
    p1_req = 1; p1_row = 0; p1_col = 0;
    repeat (4) cyc();
    reset_all();
    repeat (4) begin
      frame_tick = 1; cyc();
      frame_tick = 0; cyc();
    end
    chk("rst_drop_game_over", 8'(game_over), 0);
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) rd(m[0], r, c);
    reset_all();
    load(1, 0, 0, 0); load(0, 2, 2, 0); load(1, 0, 1, 1);
    shot(0, 0, 0, 0);
    shot(3, 3, 0, 0);
    shot(2, 2, 0, 0);
    shot(0, 1, 0, 0);
    rd(1, 0, 0); rd(1, 3, 3); rd(0, 3, 3);
    chk("queue_empty", 8'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mapa_shot_arbiter.md
Name: mapa_shot_arbiter

Overview:
- Turn controller and write-port arbiter for the 8x8 battleship cell-state maps drawn by the VGA map renderer.
- Holds two fleet maps: map 0 is P1's fleet, map 1 is P2's fleet.
- Sequences SETUP ship loading, then alternating P1/P2 shot requests. Resolves each shot as hit, miss or reject.
- Commits map writes only on a frame tick, so the renderer never sees a map change mid-frame. Exposes a registered read port for the renderer.

Parameters:
ROWS, 8, grid rows (1..8)
COLS, 8, grid columns (1..8)
SHIP_CELLS, 10, ship cells per fleet; a player wins when this many hits are scored on the opponent's map (1..64)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse at start of vertical blanking
start  in  1  leave SETUP, begin play with P1's turn
load_we  in  1  mark a ship cell (honoured in SETUP only)
load_map  in  1  target map for load
load_row  in  3  load row
load_col  in  3  load column
p1_req  in  1  P1 shot request (level, held until ack/reject)
p1_row  in  3  P1 target row
p1_col  in  3  P1 target column
p2_req  in  1  P2 shot request
p2_row  in  3  P2 target row
p2_col  in  3  P2 target column
turn  out  1  0 = P1 to shoot, 1 = P2 to shoot
shot_ack  out  1  one-cycle pulse: shot committed
shot_hit  out  1  valid with shot_ack: 1 = hit, 0 = miss
shot_reject  out  1  one-cycle pulse: cell already shot, same player retries
rd_map  in  1  renderer read map select
rd_row  in  3  renderer read row
rd_col  in  3  renderer read column
rd_state  out  2  cell state, 1-cycle latency: 0 water, 1 ship, 2 miss, 3 hit
game_over  out  1  level, held until rst
winner  out  1  valid when game_over: 0 = P1, 1 = P2

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - All 2x64 cells are set to 0.
  - Both hit counters are cleared.
  - State becomes SETUP.
  - turn, shot_ack, shot_hit, shot_reject, game_over, winner and rd_state are all 0.
  - Both re-arm flags are set (armed).
  - rst mid-shot or in WAIT_FRAME discards the pending shot with no write and no ack.
- States: SETUP, TURN, RESOLVE, WAIT_FRAME, GAME_OVER.
- SETUP:
  - load_we writes state 1 to cell (load_map, load_row, load_col).
  - A load to a cell with row >= ROWS or col >= COLS is ignored.
  - start moves to TURN with turn = 0. If start and load_we occur in the same cycle, the load is performed first.
  - load_we outside SETUP is ignored.
- TURN:
  - Only the requester selected by turn is sampled. The other player's req is ignored, even if asserted simultaneously.
  - A request is accepted when req is high and that player's re-arm flag is set. Acceptance latches row/col, targets the opponent's map (P1 shoots map 1), and moves to RESOLVE.
  - Out-of-range row/col counts as a reject.
- RESOLVE (1 cycle), reads the target cell:
  - State 2 or 3 → shot_reject pulses next cycle. Return to TURN; turn is unchanged; re-arm flag cleared.
  - State 0 or 1 → go to WAIT_FRAME.
- WAIT_FRAME:
  - Waits for frame_tick.
  - On the cycle frame_tick is sampled: write 3 (if cell was 1) or 2 (if cell was 0), and increment the shooter's hit counter on a hit.
  - Next cycle: shot_ack = 1 and shot_hit valid; the shooter's re-arm flag is cleared.
  - A frame_tick during TURN/RESOLVE has no effect.
- Re-arm: a player's re-arm flag sets on any cycle that player's req is low. A req held high across an ack/reject never causes a second shot.
- After commit:
  - If the shooter's hit count equals SHIP_CELLS → GAME_OVER, with winner = shooter and game_over = 1 in the same cycle as shot_ack.
  - Otherwise → TURN, with turn toggled.
- GAME_OVER: all requests and loads are ignored until rst. rd_state remains readable.
- Read port:
  - rd_state is registered from (rd_map, rd_row, rd_col) every cycle in all states.
  - A committed write is visible on rd_state for reads issued in the cycle after commit.
  - Out-of-range read returns 0.
- Hit counters are 7 bits and saturate at SHIP_CELLS; they cannot wrap.

Optional Feature:
- Macro: MAPA_HIT_REPEAT_EN.
- Defined: on a hit that does not end the game, turn is not toggled; the same player shoots again once re-armed. A miss still toggles turn.
- Undefined: turn toggles after every committed shot.

Test Plan:
- Reset, then read all 128 cells → rd_state = 0 everywhere; turn = 0, game_over = 0.
- SETUP: load map1 (2,3), start; P1 req (2,3); frame_tick 5 cycles later → no write before the tick; shot_ack with shot_hit = 1 the cycle after the tick; map1 (2,3) reads 3; turn = 1 (feature off).
- P2 req (0,0) on water → ack, shot_hit = 0, map0 (0,0) = 2. Then P1 repeats (2,3) → shot_reject pulse, no frame wait, turn stays 0. P1 holding req high → no second reject until req has dropped for one cycle.
- P1 and P2 req in the same cycle with turn = 0 → only P1 is serviced; P2's req is ignored until turn = 1.
- SHIP_CELLS = 2, two P1 hits → game_over = 1 and winner = 0 on the second ack; later reqs, loads and start are ignored. rst mid-WAIT_FRAME → no ack; all cells read 0.
- With MAPA_HIT_REPEAT_EN defined, a P1 hit → turn stays 0; a P1 miss → turn = 1.
